// File: rtl/bimux_arbiter_if.sv
// Handshake bundle between the requesters and the bidirectional-mux arbiter.
// The master side drives requests and directions; the slave side (the arbiter)
// returns the mux select, direction, drive enable, grant and busy status.
interface bimux_arbiter_if;
  logic [7:0] req;
  logic [7:0] rdir;
  logic [2:0] sel;
  logic       dir;
  logic       bus_en;
  logic [7:0] gnt;
  logic       busy;

  modport master (
    output req, rdir,
    input  sel, dir, bus_en, gnt, busy
  );

  modport slave (
    input  req, rdir,
    output sel, dir, bus_en, gnt, busy
  );
endinterface

// File: rtl/bimux_arbiter.sv
// Round-robin arbiter for an 8:1 bidirectional mux on a shared line.
// Each grant runs IDLE -> SETUP -> XFER -> TURN, so sel/dir settle for one
// cycle before drive and the line gets a turnaround cycle after it.
// Optional feature: define BIMUX_ARBITER_BURST_LIMIT_EN to cap a transfer at
// 4 consecutive XFER cycles; without it a transfer lasts while req[sel] holds.
module bimux_arbiter (
  input  logic            clk,
  input  logic            rst,
  bimux_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, TURN} state_t;

  state_t     state;
  logic [2:0] ptr;        // last requester served; search starts one above it
  logic [2:0] winner;
  logic [2:0] cand;
  logic       xfer_done;

`ifdef BIMUX_ARBITER_BURST_LIMIT_EN
  localparam int unsigned BURST_MAX = 4;
  logic [1:0] burst_cnt;  // XFER cycles already spent in the current burst
`endif

  // Round-robin pick: walk from the farthest candidate to the nearest so the
  // requester closest above ptr is the one that sticks.
  // NOTE: every variable written here gets a default first; skipping one on
  // some path would infer a latch.
  always_comb begin
    winner = ptr;
    cand   = '0;
    for (int i = 8; i >= 1; i--) begin
      cand = ptr + 3'(i);
      if (bus.req[cand]) winner = cand;
    end
  end

  // End-of-transfer condition: requester released the line, or burst cap hit.
`ifdef BIMUX_ARBITER_BURST_LIMIT_EN
  assign xfer_done = !bus.req[bus.sel] || (burst_cnt == 2'(BURST_MAX - 1));
`else
  assign xfer_done = !bus.req[bus.sel];
`endif

  // Arbiter FSM with all outputs registered; reset wins over every transition.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'd7;
      bus.sel    <= '0;
      bus.dir    <= 1'b0;
      bus.bus_en <= 1'b0;
      bus.gnt    <= '0;
      bus.busy   <= 1'b0;
`ifdef BIMUX_ARBITER_BURST_LIMIT_EN
      burst_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.sel  <= winner;
            bus.dir  <= bus.rdir[winner];
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          bus.bus_en <= 1'b1;
          bus.gnt    <= 8'h01 << bus.sel;
          state      <= XFER;
`ifdef BIMUX_ARBITER_BURST_LIMIT_EN
          burst_cnt  <= '0;
`endif
        end
        XFER: begin
          if (xfer_done) begin
            bus.bus_en <= 1'b0;
            bus.gnt    <= '0;
            ptr        <= bus.sel;
            state      <= TURN;
          end
`ifdef BIMUX_ARBITER_BURST_LIMIT_EN
          else begin
            burst_cnt <= burst_cnt + 2'd1;
          end
`endif
        end
        TURN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
